// File: rtl/intc_sched_pkg.sv
// intc_sched_pkg: shared defaults, FSM state codes and vector address helper
package intc_sched_pkg;
   localparam int          N_SRC_DEF      = 4;
   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
   localparam logic [1:0]  S_IDLE         = 2'd0;
   localparam logic [1:0]  S_ASSERT       = 2'd1;
   localparam logic [1:0]  S_SERVICE      = 2'd2;
   function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] stride, input logic [3:0] id);
      return base + 32'(id) * stride;
   endfunction
endpackage

// File: rtl/intc_sched_if.sv
// intc_sched_if: completion events, mask port and CPU interrupt handshake
interface intc_sched_if #(parameter int N_SRC = intc_sched_pkg::N_SRC_DEF);
   localparam int ID_W = $clog2(N_SRC);
   logic [N_SRC-1:0] done;
   logic             iack;
   logic             eoi;
   logic             mask_we;
   logic [N_SRC-1:0] mask_wdata;
   logic             irq;
   logic [31:0]      PC_handler;
   logic [ID_W-1:0]  irq_id;
   logic [N_SRC-1:0] pending;
   logic             in_service;
   modport slave (input done, iack, eoi, mask_we, mask_wdata,
                  output irq, PC_handler, irq_id, pending, in_service);
   modport master (output done, iack, eoi, mask_we, mask_wdata,
                   input irq, PC_handler, irq_id, pending, in_service);
endinterface

// File: rtl/intc_sched_rr_arbiter.sv
// intc_sched_rr_arbiter: combinational round-robin search starting at ptr with wrap
module intc_sched_rr_arbiter #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_id
);
   int idx;
   // scan farthest-to-nearest so the request closest to ptr is the last one kept
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = W'(idx);
         end
      end
   end
endmodule

// File: rtl/intc_sched.sv
// intc_sched: captures done edges as pending events, masks them, and runs irq/iack/eoi
module intc_sched
   import intc_sched_pkg::*;
#(
   parameter int          N_SRC      = N_SRC_DEF,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
   localparam int         ID_W       = $clog2(N_SRC)
) (
   input  logic        clk,
   input  logic        rst,
   intc_sched_if.slave bus
);
   logic [1:0]       state;
   logic [N_SRC-1:0] done_q;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;
   logic [ID_W-1:0]  rr;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_valid;

   assign rise = bus.done & ~done_q;
   // a fresh edge on the source being acknowledged re-sets its pending bit
   assign clr  = (state == S_ASSERT && bus.iack) ? N_SRC'(1) << bus.irq_id : '0;

   intc_sched_rr_arbiter #(.N(N_SRC)) u_arb (
      .req       (bus.pending & ~mask),
      .ptr       (rr),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // edge capture, pending accumulation and mask register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q      <= '0;
         bus.pending <= '0;
         mask        <= '0;
      end else begin
         done_q      <= bus.done;
         bus.pending <= (bus.pending & ~clr) | rise;
         if (bus.mask_we) mask <= bus.mask_wdata;
      end
   end

   // grant / acknowledge / end-of-interrupt sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         bus.irq        <= 1'b0;
         bus.PC_handler <= '0;
         bus.irq_id     <= '0;
         bus.in_service <= 1'b0;
         rr             <= '0;
      end else begin
         case (state)
            S_IDLE: if (gnt_valid) begin
               bus.irq_id     <= gnt_id;
               bus.PC_handler <= vec_addr(VEC_BASE, VEC_STRIDE, 4'(gnt_id));
               bus.irq        <= 1'b1;
               state          <= S_ASSERT;
            end
            S_ASSERT: if (bus.iack) begin
               bus.irq        <= 1'b0;
               bus.in_service <= 1'b1;
               rr             <= (bus.irq_id == ID_W'(N_SRC - 1)) ? '0 : bus.irq_id + ID_W'(1);
               state          <= S_SERVICE;
            end
            S_SERVICE: if (bus.eoi) begin
               bus.in_service <= 1'b0;
               state          <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_intc_sched.sv
// tb_intc_sched: table-driven and directed checks of the interrupt scheduler
module tb_intc_sched;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   intc_sched_if #(.N_SRC(4)) bus ();
   intc_sched #(.N_SRC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [3:0]  done;
      logic        iack;
      logic        eoi;
      logic        mwe;
      logic [3:0]  mwd;
      logic        irq;
      logic [1:0]  id;
      logic [31:0] pc;
      logic [3:0]  pend;
      logic        insvc;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_irq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] d, input logic ik, input logic ek, input logic mw, input logic [3:0] md);
      bus.done = d; bus.iack = ik; bus.eoi = ek; bus.mask_we = mw; bus.mask_wdata = md;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic q, input logic [1:0] id, input logic [31:0] pc, input logic [3:0] p, input logic s);
      check({tag, ".irq"}, 32'(bus.irq), 32'(q));
      check({tag, ".id"}, 32'(bus.irq_id), 32'(id));
      check({tag, ".pc"}, bus.PC_handler, pc);
      check({tag, ".pend"}, 32'(bus.pending), 32'(p));
      check({tag, ".insvc"}, 32'(bus.in_service), 32'(s));
   endtask

   function automatic vec_t mk(logic [3:0] d, logic ik, logic ek, logic mw, logic [3:0] md,
                               logic q, logic [1:0] id, logic [31:0] pc, logic [3:0] p, logic s);
      vec_t v;
      v.done = d; v.iack = ik; v.eoi = ek; v.mwe = mw; v.mwd = md;
      v.irq = q; v.id = id; v.pc = pc; v.pend = p; v.insvc = s;
      return v;
   endfunction

   initial begin
      // all four sources together, served 0..3, then idle with stray iack/eoi
      tbl.push_back(mk(4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 32'h000, 4'hF, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 32'h100, 4'hF, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 32'h100, 4'hE, 1'b1));
      tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 32'h100, 4'hE, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 32'h110, 4'hE, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 32'h110, 4'hC, 1'b1));
      tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 32'h110, 4'hC, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 32'h120, 4'hC, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 32'h120, 4'h8, 1'b1));
      tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 32'h120, 4'h8, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 32'h130, 4'h8, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h0, 1'b1));
      tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h0, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h0, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h0, 1'b0));
      // masked source stays pending, unmask releases it, mask in ASSERT keeps irq
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 2'd3, 32'h130, 4'h0, 1'b0));
      tbl.push_back(mk(4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h1, 1'b0));
      tbl.push_back(mk(4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 32'h130, 4'h1, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd3, 32'h130, 4'h1, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 32'h100, 4'h1, 1'b0));
      tbl.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0, 32'h100, 4'h1, 1'b0));
      tbl.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 32'h100, 4'h0, 1'b1));
      tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 32'h100, 4'h0, 1'b0));

      bus.done = '0; bus.iack = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
      rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].done, tbl[i].iack, tbl[i].eoi, tbl[i].mwe, tbl[i].mwd);
         chk_all($sformatf("row%0d", i), tbl[i].irq, tbl[i].id, tbl[i].pc, tbl[i].pend, tbl[i].insvc);
      end

      // serve id1, then 0 and 2 together: pointer at 2 picks 2 before 0
      step(4'h2, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("rr.id1", 1'b1, 2'd1, 32'h110, 4'h2, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
      step(4'h5, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("rr.id2", 1'b1, 2'd2, 32'h120, 4'h5, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("rr.id0", 1'b1, 2'd0, 32'h100, 4'h1, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);

      // done3 held high for 10 cycles yields a single request
      n_irq = 0;
      for (int i = 0; i < 10; i++) begin
         step(4'h8, bus.irq, bus.in_service, 1'b0, 4'h0);
         if (bus.irq) n_irq++;
      end
      check("hold.count", 32'(n_irq), 32'd1);
      check("hold.irq", 32'(bus.irq), 32'd0);
      check("hold.pend", 32'(bus.pending), 32'd0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h8, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h8, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("hold.re", 1'b1, 2'd3, 32'h130, 4'h8, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);

      // new edge on id1 during its iack wins; iack+eoi in ASSERT acts as iack only
      step(4'h2, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("race.req", 1'b1, 2'd1, 32'h110, 4'h2, 1'b0);
      step(4'h2, 1'b1, 1'b0, 1'b0, 4'h0);
      chk_all("race.ack", 1'b0, 2'd1, 32'h110, 4'h2, 1'b1);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("race.again", 1'b1, 2'd1, 32'h110, 4'h2, 1'b0);
      step(4'h0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk_all("both", 1'b0, 2'd1, 32'h110, 4'h0, 1'b1);
      step(4'h0, 1'b0, 1'b1, 1'b0, 4'h0);

      // asynchronous reset while asserting drops everything immediately
      step(4'h4, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
      step(4'h8, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("prerst", 1'b1, 2'd2, 32'h120, 4'hC, 1'b0);
      bus.done = '0;
      #2 rst = 1'b0;
      #1 chk_all("async", 1'b0, 2'd0, 32'h0, 4'h0, 1'b0);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
         check($sformatf("postrst%0d", i), 32'(bus.irq), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
